// File: rtl/imem_program_loader_if.sv
// Host byte stream (valid/ready) and instruction-memory write port seen by the loader.
// The master modport is the loader side; the slave modport is the host/memory side.
interface imem_program_loader_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_program_loader.sv
// Loads a length-prefixed, XOR-checksummed program image into instruction memory
// and keeps the core in reset until a verified image has been written.
module imem_program_loader #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    imem_program_loader_if.master         bus,
    output logic                          cpu_hold,
    output logic                          done,
    output logic                          error
);
    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERR
    } state_t;

    state_t              state_q, state_nxt;
    logic [15:0]         len;
    logic [31:0]         word;
    logic [31:0]         word_full;
    logic [1:0]          byte_cnt;
    logic [ADDR_WIDTH:0] word_idx;
    logic [7:0]          checksum;
    logic [15:0]         len_cand;
    logic                xfer;
    logic                start_ok;
    logic                len_too_big;
    logic                last_word;

    logic in_ready_nxt, imem_we_nxt, cpu_hold_nxt, done_nxt, error_nxt;

    assign xfer        = bus.in_valid && bus.in_ready;
    assign start_ok    = start && (state_q inside {IDLE, DONE, ERR});
    assign len_cand    = {bus.in_data, len[7:0]};
    assign len_too_big = 32'(len_cand) > (32'd1 << ADDR_WIDTH);
    assign last_word   = (32'(word_idx) + 32'd1) == 32'(len);

    always_comb begin
        word_full = word;
        word_full[{byte_cnt, 3'b000} +: 8] = bus.in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE, DONE, ERR: if (start) state_nxt = LEN_LO;
            LEN_LO:          if (xfer) state_nxt = LEN_HI;
            LEN_HI: begin
                if (xfer) begin
                    if (len_too_big)          state_nxt = ERR;
                    else if (len_cand == '0)  state_nxt = CHECK;
                    else                      state_nxt = DATA;
                end
            end
            DATA:  if (xfer && byte_cnt == 2'd3) state_nxt = WRITE;
            WRITE: state_nxt = last_word ? CHECK : DATA;
            CHECK: if (xfer) state_nxt = (bus.in_data == checksum) ? DONE : ERR;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up
    // with the state they describe and in_ready has no path from in_valid.
    always_comb begin
        in_ready_nxt = state_nxt inside {LEN_LO, LEN_HI, DATA, CHECK};
        imem_we_nxt  = state_nxt == WRITE;
        cpu_hold_nxt = state_nxt != DONE;
        done_nxt     = state_nxt == DONE;
        error_nxt    = state_nxt == ERR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.in_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_hold       <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            bus.in_ready <= in_ready_nxt;
            bus.imem_we  <= imem_we_nxt;
            cpu_hold     <= cpu_hold_nxt;
            done         <= done_nxt;
            error        <= error_nxt;
            if (state_nxt == WRITE) begin
                bus.imem_addr  <= word_idx[ADDR_WIDTH-1:0];
                bus.imem_wdata <= word_full;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len      <= '0;
            word     <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
            checksum <= '0;
        end else if (start_ok) begin
            len      <= '0;
            word     <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
            checksum <= '0;
        end else begin
            if (state_q == LEN_LO && xfer) len[7:0]  <= bus.in_data;
            if (state_q == LEN_HI && xfer) len[15:8] <= bus.in_data;
            if (state_q == DATA && xfer) begin
                word     <= word_full;
                checksum <= checksum ^ bus.in_data;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state_q == WRITE) word_idx <= word_idx + (ADDR_WIDTH+1)'(1);
        end
    end
endmodule
